// File: rtl/down_counter_ctrl.sv
// Sequencer for a down-counter: takes a load/prescale/reload config, then counts down
// with prescaled ticks. Supports pause/resume and abort, and flags the terminal count.
module down_counter_ctrl #(
  parameter int WIDTH      = 6,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_load,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_reload,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  abort,
  output logic [WIDTH-1:0]      count,
  output logic [2:0]            state,
  output logic                  busy,
  output logic                  tc_pulse,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [WIDTH-1:0]      CNT_INIT = '1;
  localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        count_q, count_d;
  logic [PRESCALE_W-1:0]   pcnt_q, pcnt_d;
  logic [WIDTH-1:0]        load_q, load_d;
  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic                    reload_q, reload_d;
  logic                    tc_q, tc_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cfg_fire;
  logic                    run_step;
  logic                    tick;

  // Saturating decrement: the counter stops at zero rather than wrapping.
  function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] c);
    return (c == '0) ? '0 : c - CNT_ONE;
  endfunction

  function automatic logic [PRESCALE_W-1:0] pcnt_adv(input logic [PRESCALE_W-1:0] p,
                                                     input logic [PRESCALE_W-1:0] lim);
    return (p == lim) ? '0 : p + PCNT_ONE;
  endfunction

  assign cfg_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign tick      = (pcnt_q == presc_q);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pcnt_d   = pcnt_q;
    load_d   = load_q;
    presc_d  = presc_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    run_step = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      count_d = CNT_INIT;
      pcnt_d  = '0;
    end else if (cfg_fire) begin
      load_d   = cfg_load;
      presc_d  = cfg_prescale;
      reload_d = cfg_reload;
      count_d  = cfg_load;
      pcnt_d   = '0;
      state_d  = S_ARMED;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (start) begin
            state_d = S_RUN;
            pcnt_d  = '0;
          end
        end
        S_RUN: begin
          if (pause) state_d = S_PAUSE;
          else       run_step = 1'b0 | 1'b1;
        end
        // Leaving PAUSE is itself a counting cycle, so a pause of N cycles delays by exactly N.
        S_PAUSE: begin
          if (!pause) begin
            state_d  = S_RUN;
            run_step = 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state_d = S_RUN;
            count_d = load_q;
            pcnt_d  = '0;
          end
        end
        default: ;
      endcase

      if (run_step) begin
        pcnt_d = pcnt_adv(pcnt_q, presc_q);
        if (tick) begin
          if (count_q != '0) begin
            count_d = dec_sat(count_q);
          end else begin
            tc_d = 1'b1;
            if (reload_q) count_d = load_q;
            else          state_d = S_DONE;
          end
        end
      end
    end

    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= CNT_INIT;
      pcnt_q   <= '0;
      load_q   <= '0;
      presc_q  <= '0;
      reload_q <= 1'b0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pcnt_q   <= pcnt_d;
      load_q   <= load_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count    = count_q;
  assign state    = state_q;
  assign busy     = busy_q;
  assign tc_pulse = tc_q;
  assign done     = done_q;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed bench for down_counter_ctrl: each task drives one scenario and checks
// outputs against hand-computed values, sampled 1 time unit after the rising edge.
module tb_down_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_load;
  logic [3:0] cfg_prescale;
  logic       cfg_reload;
  logic       start;
  logic       pause;
  logic       abort;
  logic [5:0] count;
  logic [2:0] state;
  logic       busy;
  logic       tc_pulse;
  logic       done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  down_counter_ctrl #(.WIDTH(6), .PRESCALE_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_load(cfg_load), .cfg_prescale(cfg_prescale), .cfg_reload(cfg_reload),
    .start(start), .pause(pause), .abort(abort),
    .count(count), .state(state), .busy(busy), .tc_pulse(tc_pulse), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_cfg(input logic [5:0] l, input logic [3:0] p, input logic r);
    cfg_valid = 1'b1; cfg_load = l; cfg_prescale = p; cfg_reload = r;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (count !== 6'd63) begin failures++; $display("FAIL rst_count got=%0d exp=63", count); end
    checks++; if (tc_pulse !== 1'b0) begin failures++; $display("FAIL rst_tc got=%0b exp=0", tc_pulse); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done got=%0b%0b exp=00", busy, done); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_cfg_ready got=%0b exp=1", cfg_ready); end
    rst_n = 1'b1;
    step();
    // start in IDLE with no config must be ignored
    pulse_start();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL idle_start got=%0d exp=0", state); end
  endtask

  task automatic test_async_reset();
    apply_cfg(6'd5, 4'd3, 1'b0);
    pulse_start();
    checks++; if (state !== 3'd2 || count !== 6'd5) begin failures++; $display("FAIL ar_run got=%0d/%0d exp=2/5", state, count); end
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 6'd63) begin failures++; $display("FAIL ar_count got=%0d exp=63", count); end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL ar_state got=%0d exp=0", state); end
    checks++; if (tc_pulse !== 1'b0 || cfg_ready !== 1'b1) begin failures++; $display("FAIL ar_tc_ready got=%0b%0b exp=01", tc_pulse, cfg_ready); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    apply_cfg(6'd3, 4'd0, 1'b0);
    checks++; if (state !== 3'd1 || count !== 6'd3) begin failures++; $display("FAIL sg_armed got=%0d/%0d exp=1/3", state, count); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL sg_ready_armed got=%0b exp=0", cfg_ready); end
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      checks++; if (count !== 6'(3 - i) || state !== 3'd2 || busy !== 1'b1) begin
        failures++; $display("FAIL sg_cnt%0d got=%0d st=%0d exp=%0d st=2", i, count, state, 3 - i);
      end
      step();
    end
    checks++; if (tc_pulse !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL sg_tc got=%0b%0b exp=11", tc_pulse, done); end
    checks++; if (count !== 6'd0 || state !== 3'd4) begin failures++; $display("FAIL sg_done got=%0d/%0d exp=0/4", count, state); end
    step();
    checks++; if (tc_pulse !== 1'b0 || count !== 6'd0 || done !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++; $display("FAIL sg_hold got tc=%0b cnt=%0d done=%0b rdy=%0b exp=0/0/1/1", tc_pulse, count, done, cfg_ready);
    end
  endtask

  task automatic test_reload();
    apply_cfg(6'd1, 4'd2, 1'b1);
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      logic [5:0] ec;
      logic       et;
      ec = ((i % 6) < 3) ? 6'd1 : 6'd0;
      et = (i > 0) && ((i % 6) == 0);
      checks++; if (count !== ec || tc_pulse !== et) begin
        failures++; $display("FAIL rl_c%0d got cnt=%0d tc=%0b exp cnt=%0d tc=%0b", i, count, tc_pulse, ec, et);
      end
      step();
    end
    checks++; if (count !== 6'd1 || tc_pulse !== 1'b1 || state !== 3'd2) begin
      failures++; $display("FAIL rl_wrap got cnt=%0d tc=%0b st=%0d exp 1/1/2", count, tc_pulse, state);
    end
  endtask

  task automatic test_pause();
    step();
    pause = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (state !== 3'd3 || count !== 6'd1 || tc_pulse !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL ps_frz%0d got st=%0d cnt=%0d tc=%0b exp 3/1/0", k, state, count, tc_pulse);
      end
    end
    pause = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      logic [5:0] ec;
      step();
      ec = (k == 1 || k == 5) ? 6'd1 : 6'd0;
      checks++; if (tc_pulse !== (k == 5) || count !== ec || state !== 3'd2) begin
        failures++; $display("FAIL ps_res%0d got tc=%0b cnt=%0d st=%0d exp tc=%0b cnt=%0d st=2", k, tc_pulse, count, state, (k == 5), ec);
      end
    end
  endtask

  task automatic test_abort();
    pause = 1'b1;
    step();
    checks++; if (state !== 3'd3 || count !== 6'd1) begin failures++; $display("FAIL ab_pre got=%0d/%0d exp=3/1", state, count); end
    abort = 1'b1; pause = 1'b0;
    step();
    abort = 1'b0;
    checks++; if (state !== 3'd0 || count !== 6'd63) begin failures++; $display("FAIL ab_idle got=%0d/%0d exp=0/63", state, count); end
    checks++; if (busy !== 1'b0 || tc_pulse !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL ab_flags got=%0b%0b%0b exp=000", busy, tc_pulse, done); end
    pulse_start();
    checks++; if (state !== 3'd0 || count !== 6'd63 || tc_pulse !== 1'b0) begin
      failures++; $display("FAIL ab_start got st=%0d cnt=%0d tc=%0b exp 0/63/0", state, count, tc_pulse);
    end
  endtask

  task automatic test_cfg_blocked();
    apply_cfg(6'd2, 4'd0, 1'b0);
    pulse_start();
    cfg_valid = 1'b1; cfg_load = 6'd9; cfg_prescale = 4'd5; cfg_reload = 1'b1;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL cb_ready got=%0b exp=0", cfg_ready); end
    step();
    checks++; if (count !== 6'd1 || state !== 3'd2) begin failures++; $display("FAIL cb_cnt got=%0d/%0d exp=1/2", count, state); end
    step();
    cfg_valid = 1'b0;
    step();
    checks++; if (tc_pulse !== 1'b1 || state !== 3'd4) begin failures++; $display("FAIL cb_done got tc=%0b st=%0d exp 1/4", tc_pulse, state); end
    // restart from DONE reuses the originally latched load, not the rejected one
    pulse_start();
    checks++; if (state !== 3'd2 || count !== 6'd2) begin failures++; $display("FAIL cb_restart got=%0d/%0d exp=2/2", state, count); end
    repeat (3) step();
    checks++; if (tc_pulse !== 1'b1 || state !== 3'd4) begin failures++; $display("FAIL cb_done2 got tc=%0b st=%0d exp 1/4", tc_pulse, state); end
    cfg_valid = 1'b1; cfg_load = 6'd0; cfg_prescale = 4'd0; cfg_reload = 1'b0; start = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++; if (state !== 3'd1 || count !== 6'd0 || tc_pulse !== 1'b0) begin
      failures++; $display("FAIL cb_cfg_wins got st=%0d cnt=%0d tc=%0b exp 1/0/0", state, count, tc_pulse);
    end
    step();
    start = 1'b0;
    checks++; if (state !== 3'd2 || tc_pulse !== 1'b0) begin failures++; $display("FAIL cb_run0 got st=%0d tc=%0b exp 2/0", state, tc_pulse); end
    step();
    checks++; if (tc_pulse !== 1'b1 || state !== 3'd4) begin failures++; $display("FAIL cb_load0 got tc=%0b st=%0d exp 1/4", tc_pulse, state); end
  endtask

  task automatic test_zero_reload();
    apply_cfg(6'd0, 4'd0, 1'b1);
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (tc_pulse !== 1'b1 || count !== 6'd0 || state !== 3'd2) begin
        failures++; $display("FAIL zr_%0d got tc=%0b cnt=%0d st=%0d exp 1/0/2", k, tc_pulse, count, state);
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (tc_pulse !== 1'b0 || state !== 3'd0 || count !== 6'd63) begin
      failures++; $display("FAIL zr_abort got tc=%0b st=%0d cnt=%0d exp 0/0/63", tc_pulse, state, count);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_load = '0; cfg_prescale = '0; cfg_reload = 1'b0;
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    repeat (2) step();
    test_reset();
    test_async_reset();
    test_single();
    test_reload();
    test_pause();
    test_abort();
    test_cfg_blocked();
    test_zero_reload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completion");
    $fatal(1);
  end

endmodule
